sram_ctrl_multibeat: RTL

- Parametrised SRAM controller between the memory stage and external 16-bit asynchronous SRAM.
- Splits each DATA_W-bit access into BEATS = DATA_W/16 sequential SRAM beats, with programmable cycles per beat and byte-lane masking.
- Uses a valid/ready request handshake and a one-cycle completion pulse.
- busy freezes the upstream pipeline while an access is in flight.

---
 rtl/sram_ctrl_multibeat_pkg.sv | 21 ++
 rtl/sram_ctrl_multibeat_beat_sequencer.sv | 43 ++++
 rtl/sram_ctrl_multibeat.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_multibeat_pkg.sv
// Shared types and sizing helpers for the multi-beat SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int SRAM_DQ_W = 16;

  function automatic int beats(input int data_w);
    return data_w / SRAM_DQ_W;
  endfunction

  // Bits needed to index 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_ctrl_multibeat_beat_sequencer.sv
// Beat index and cycle-in-beat timing for one SRAM access; idles at beat 0, first cycle.
module sram_beat_sequencer
  import sram_ctrl_pkg::*;
#(
  parameter int BEATS       = 2,
  parameter int WAIT_CYCLES = 2,
  localparam int BEAT_W     = cnt_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              first_cyc,
  output logic              last_cyc,
  output logic              last_beat
);

  localparam int CYC_W = cnt_w(WAIT_CYCLES);
  localparam logic [CYC_W-1:0]  CYC_TOP  = CYC_W'(WAIT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_TOP = BEAT_W'(BEATS - 1);

  logic [CYC_W-1:0] cyc_left;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_left <= CYC_TOP;
      beat_idx <= '0;
    end else if (!run) begin
      cyc_left <= CYC_TOP;
      beat_idx <= '0;
    end else if (last_cyc) begin
      cyc_left <= CYC_TOP;
      beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
    end else begin
      cyc_left <= cyc_left - 1'b1;
    end
  end

  assign first_cyc = (cyc_left == CYC_TOP);
  assign last_cyc  = (cyc_left == '0);
  assign last_beat = (beat_idx == BEAT_TOP);

endmodule

// File: rtl/sram_ctrl_multibeat.sv
// Splits a DATA_W access into 16-bit asynchronous SRAM beats with byte-lane masking.
//   state  | meaning
//   IDLE   | req_ready high, waiting for req_valid
//   ACCESS | beats in progress, ce_n low
//   DONE   | one-cycle rsp_valid, strobes released
module sram_ctrl_multibeat
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_be,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_lb_n,
  output logic                   sram_ub_n
);

  localparam int BEATS   = beats(DATA_W);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int BEAT_W  = cnt_w(BEATS);

  state_t state, state_nxt;

  logic [SRAM_ADDR_W-1:0] base_q;
  logic                   write_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W/8-1:0]    be_q;
  logic [DATA_W-1:0]      shadow, shadow_nxt;
  logic [31:0]            word_addr;

  logic [BEAT_W-1:0]      beat_idx;
  logic                   first_cyc, last_cyc, last_beat;
  logic [SRAM_DQ_W-1:0]   wdata_beat;
  logic [1:0]             be_beat;
  logic                   drive_en;
  logic                   accept, beat_end;

  sram_beat_sequencer #(
    .BEATS      (BEATS),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .run      (state == ACCESS),
    .beat_idx (beat_idx),
    .first_cyc(first_cyc),
    .last_cyc (last_cyc),
    .last_beat(last_beat)
  );

  assign accept     = (state == IDLE) && req_valid;
  assign beat_end   = (state == ACCESS) && last_cyc;
  assign word_addr  = req_addr >> BYTE_SH;
  assign wdata_beat = wdata_q[SRAM_DQ_W*beat_idx +: SRAM_DQ_W];
  assign be_beat    = be_q[2*beat_idx +: 2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes decode only from flops so they reach reset values without a clock.
  always_comb begin
    state_nxt = state;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_lb_n = 1'b1;
    sram_ub_n = 1'b1;
    drive_en  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        sram_ce_n = 1'b0;
        if (write_q) begin
          drive_en  = 1'b1;
          sram_lb_n = ~be_beat[0];
          sram_ub_n = ~be_beat[1];
          sram_we_n = first_cyc || (be_beat == 2'b00);
        end else begin
          sram_oe_n = 1'b0;
          sram_lb_n = 1'b0;
          sram_ub_n = 1'b0;
        end
        if (last_cyc && last_beat) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    if (beat_end && !write_q) shadow_nxt[SRAM_DQ_W*beat_idx +: SRAM_DQ_W] = sram_dq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      shadow    <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        base_q  <= SRAM_ADDR_W'(word_addr * BEATS);
        write_q <= req_write;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      shadow <= shadow_nxt;
      if (beat_end && last_beat && !write_q) rsp_rdata <= shadow_nxt;
    end
  end

  assign sram_dq   = drive_en ? wdata_beat : 16'hzzzz;
  assign sram_addr = base_q + SRAM_ADDR_W'(beat_idx);
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state == DONE);

endmodule
